right_shift_ser_ctrl: RTL
=========================

// Module: right_shift_ser_ctrl
// PURPOSE
//  Sequencer for a right-shift register: accepts a parallel word on a valid/ready handshake, loads it
//  via sr_load, then drives sr_en for DW cycles to shift it out LSB-first, sampling the register's q[0].
//  Presents the bit stream as ser_out/ser_valid/ser_last.
//  Sits between a word producer and one external right-shift register instance.
// PARAMETERS
//  DW    4     word width / number of shift cycles per word (>=2)
//  CW    2     shift-counter width; must satisfy 2**CW >= DW
//  FILL  1'b0  constant driven on sr_data_h (bit shifted into the MSB)
// PORTS
//  clk          in   1   clock, rising edge
//  async_rst    in   1   asynchronous active-high reset
//  in_valid     in   1   producer has a word
//  in_ready     out  1   controller can accept; transfer = in_valid & in_ready at rising edge
//  in_data      in   DW  parallel word
//  sr_sync_rst  out  1   synchronous clear to shift register
//  sr_load      out  1   load strobe to shift register
//  sr_en        out  1   shift enable to shift register
//  sr_data      out  DW  captured word presented to shift register
//  sr_data_h    out  1   serial fill bit (= FILL)
//  sr_q0        in   1   shift register q[0]
//  ser_out      out  1   serial bit (= sr_q0 while ser_valid; 0 otherwise)
//  ser_valid    out  1   ser_out carries a valid bit this cycle
//  ser_last     out  1   final bit of the current word
//  busy         out  1   high in LOAD/SHIFT(/PAR)
// BEHAVIOUR
//  - States: INIT, IDLE, LOAD, SHIFT (+PAR with option). Outputs decoded from state/count/word regs only;
//    no combinational path from in_valid/in_data to any output.
//  - Reset: async_rst=1 forces INIT, count=0, word=0 immediately. All outputs 0 in INIT except sr_sync_rst=1.
//    First edge after release: INIT->IDLE (exactly one sr_sync_rst cycle clears stale register content).
//  - IDLE: in_ready=1. On transfer, capture in_data into word reg; ->LOAD. Otherwise stay in IDLE.
//  - LOAD: in_ready=0, sr_load=1, sr_en=0, busy=1; ->SHIFT with count=0. Register holds word after this edge.
//  - SHIFT: sr_en=1, ser_valid=1, ser_out=sr_q0 (bit[count] of word), count++ per edge.
//    ser_last=1 and in_ready=1 when count==DW-1 only.
//    At count==DW-1: transfer -> capture, ->LOAD (back-to-back, one-cycle gap);
//    no transfer -> IDLE, count=0.
//  - Throughput: DW+1 cycles/word. Latency: accept edge -> first ser_valid = 2 edges.
//  - in_data/in_valid changes while in_ready=0 are ignored; word reg is stable from capture to next capture.
//  - Counter never wraps: cleared on LOAD->SHIFT entry; values > DW-1 unreachable.
//  - Reset mid-word: outputs drop asynchronously; remaining bits are discarded, never emitted after reset.
//  - sr_data_h is tied to FILL in every state.
// CONFIGURATION
//  SHIFT_CTRL_PARITY_EN defined:
//    - After bit DW-1, one extra PAR cycle: sr_en=0, ser_valid=1, ser_out = ^word (even parity).
//    - ser_last and in_ready move from the last data bit to PAR; PAR exits exactly as the last SHIFT cycle.
//    - Throughput DW+2.
//  Not defined: no PAR state; behaviour exactly as above.
// TESTING (DW=4, FILL=0, bench models the shift register: load priority over en)
//  1 async_rst pulse mid-cycle -> all outputs 0 at once, sr_sync_rst=1 for one cycle after release,
//    then in_ready=1.
//  2 accept 4'b1011 at edge T -> sr_load=1 in T..T+1; ser_out 1,1,0,1 in cycles T+1..T+4,
//    ser_last in the 4th; IDLE after.
//  3 in_valid held with 4'hA then 4'h5 -> stream 0,1,0,1,<gap>,1,0,1,0; 2nd word accepted on 1st
//    word's ser_last cycle; 10 cycles total.
//  4 in_valid=1, data toggling while busy -> in_ready=0, emitted bits match captured word only.
//  5 async_rst after 2 bits of 4'hF -> ser_valid=0 immediately, INIT then IDLE, no further bits.
//  6 PARITY_EN, word 4'b0111 -> 1,1,1,0 then parity 1 with ser_last; 4'b0011 -> parity 0; 6 cycles/word.

Source files
------------

// File: rtl/right_shift_ser_ctrl_if.sv
// Purpose : bundles the word handshake, shift-register control/data and serial output of right_shift_ser_ctrl.
// Latency : none (wires only).
// Backpressure: in_valid/in_ready handshake; no backpressure on the serial output side.
// Ports   : in_valid/in_ready/in_data (word producer), sr_* (external right-shift register),
//           ser_out/ser_valid/ser_last (bit stream), busy (status).
// Modports: slave = controller view, master = surrounding environment view.
interface right_shift_ser_ctrl_if #(
    parameter int DW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          sr_sync_rst;
    logic          sr_load;
    logic          sr_en;
    logic [DW-1:0] sr_data;
    logic          sr_data_h;
    logic          sr_q0;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_last;
    logic          busy;

    modport slave (
        input  in_valid, in_data, sr_q0,
        output in_ready, sr_sync_rst, sr_load, sr_en, sr_data, sr_data_h,
               ser_out, ser_valid, ser_last, busy
    );

    modport master (
        output in_valid, in_data, sr_q0,
        input  in_ready, sr_sync_rst, sr_load, sr_en, sr_data, sr_data_h,
               ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/right_shift_ser_ctrl.sv
// Purpose : sequences an external right-shift register: capture a word, load it, shift it out LSB-first.
// Latency : accept edge -> first ser_valid after 2 edges; DW+1 cycles per word (DW+2 with parity).
// Backpressure: in_ready only in IDLE and on the final bit of a word; serial side cannot be stalled.
// Ports   : clk, async_rst (async active-high) plus the slave modport of right_shift_ser_ctrl_if
//           (word handshake in, shift-register control out, sr_q0 in, ser_out/ser_valid/ser_last/busy out).
// Option  : define SHIFT_CTRL_PARITY_EN to append one even-parity bit (PAR state) after each word.
module right_shift_ser_ctrl #(
    parameter int   DW   = 4,
    parameter int   CW   = 2,
    parameter logic FILL = 1'b0
) (
    input  logic                  clk,
    input  logic                  async_rst,
    right_shift_ser_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD,
        SHIFT
`ifdef SHIFT_CTRL_PARITY_EN
        , PAR
`endif
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [DW-1:0] word,  word_nx;

    // Decoded outputs (functions of state/count/word and sr_q0 only)
    logic in_ready;
    logic sr_sync_rst;
    logic sr_load;
    logic sr_en;
    logic ser_out;
    logic ser_valid;
    logic ser_last;
    logic busy;
    logic xfer;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state <= INIT;
            count <= '0;
            word  <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            word  <= word_nx;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = 1'b0;
        sr_sync_rst = 1'b0;
        sr_load     = 1'b0;
        sr_en       = 1'b0;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        ser_last    = 1'b0;
        busy        = 1'b0;
        case (state)
            INIT: begin
                // One clear cycle wipes whatever the register held before reset.
                sr_sync_rst = 1'b1;
            end
            IDLE: begin
                in_ready = 1'b1;
            end
            LOAD: begin
                sr_load = 1'b1;
                busy    = 1'b1;
            end
            SHIFT: begin
                sr_en     = 1'b1;
                ser_valid = 1'b1;
                ser_out   = bus.sr_q0;
                busy      = 1'b1;
`ifndef SHIFT_CTRL_PARITY_EN
                // Opening in_ready on the last bit lets the next word load with a single gap cycle.
                ser_last  = (count == LAST);
                in_ready  = (count == LAST);
`endif
            end
`ifdef SHIFT_CTRL_PARITY_EN
            PAR: begin
                // Register is not shifted here; the bit comes from the held word copy.
                ser_valid = 1'b1;
                ser_out   = ^word;
                ser_last  = 1'b1;
                in_ready  = 1'b1;
                busy      = 1'b1;
            end
`endif
            default: begin
                sr_sync_rst = 1'b0;
            end
        endcase
    end

    assign xfer = bus.in_valid & in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        count_nx = count;
        word_nx  = word;
        case (state)
            INIT: begin
                state_nx = IDLE;
            end
            IDLE: begin
                if (xfer) begin
                    word_nx  = bus.in_data;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = SHIFT;
                count_nx = '0;
            end
            SHIFT: begin
                if (count == LAST) begin
                    count_nx = '0;
`ifdef SHIFT_CTRL_PARITY_EN
                    state_nx = PAR;
`else
                    if (xfer) begin
                        word_nx  = bus.in_data;
                        state_nx = LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
`endif
                end else begin
                    count_nx = count + CW'(1);
                end
            end
`ifdef SHIFT_CTRL_PARITY_EN
            PAR: begin
                count_nx = '0;
                if (xfer) begin
                    word_nx  = bus.in_data;
                    state_nx = LOAD;
                end else begin
                    state_nx = IDLE;
                end
            end
`endif
            default: begin
                state_nx = INIT;
                count_nx = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.in_ready    = in_ready;
    assign bus.sr_sync_rst = sr_sync_rst;
    assign bus.sr_load     = sr_load;
    assign bus.sr_en       = sr_en;
    assign bus.sr_data     = word;
    assign bus.sr_data_h   = FILL;
    assign bus.ser_out     = ser_out;
    assign bus.ser_valid   = ser_valid;
    assign bus.ser_last    = ser_last;
    assign bus.busy        = busy;

endmodule
